bottling_ctrl_param: RTL and testbench
======================================

Name: bottling_ctrl_param

Overview:
- Parametrised successor to the pill-bottling main controller: a six-state SETTING/RUNNING/SWITCHING/DONE/ERROR/FATAL FSM with pill and bottle counters, hopper/switch timeout supervision, an error-retry budget and beep-mode generation.
- Runs on one clock with an internal seconds tick.
- Sits between the debounced button/sensor inputs and the display/beeper layer, which consume its state, counters and beep_mode.

Parameters:
PILL_W, 10, width of pill counters/targets
BOTTLE_W, 7, width of bottle counters/targets
MAX_PILLS, 999, largest legal pills-per-bottle target
MAX_BOTTLES, 99, largest legal bottle target
TICK_DIV, 1000, clk_1khz cycles per timer tick (1 s)
HOPPER_TIMEOUT, 5, ticks without a pill in RUNNING before ERROR
SWITCH_TIMEOUT, 3, ticks without bottle_ready in SWITCHING before ERROR
MAX_RETRY, 3, ERROR entries allowed before FATAL
DONE_BEEP_S, 2, ticks of done beep

Ports:
clk_1khz  in  1  system clock, all logic on rising edge
clr_n  in  1  reset; asynchronous, active-low
start  in  1  QD button, synchronous level, rising edge used
ack  in  1  error acknowledge, synchronous level, rising edge used
emergency_stop  in  1  synchronous level, highest priority
hopper_pulse  in  1  raw asynchronous pill-drop pulse
bottle_ready  in  1  synchronous level, next bottle in position
conveyor_fault  in  1  synchronous level
set_pills  in  PILL_W  requested pills per bottle
set_bottles  in  BOTTLE_W  requested bottle count
state  out  3  SETTING=000 RUNNING=001 SWITCHING=010 DONE=011 ERROR=100 FATAL=101
now_pills  out  PILL_W  pills in current bottle
now_bottles  out  BOTTLE_W  bottles completed
hopper_en  out  1  hopper feed enable
conveyor_run  out  1  conveyor motor enable
done  out  1  high in DONE
beep_mode  out  2  0 off, 1 4 Hz, 2 2 Hz, 3 continuous

Behaviour:
- Reset (clr_n low, async):
  - state=SETTING; counters, targets, timers, tick counter and err_count =0; all outputs 0.
  - Synchroniser/edge flops cleared.
- hopper_pulse path: 2-flop synchroniser plus edge detect. now_pills updates on the 3rd rising edge after hopper_pulse rises. start/ack: 1-flop edge detect, acted on 1 cycle after rising.
- Tick counter:
  - Counts 0..TICK_DIV-1; tick pulse when it wraps.
  - Cleared on every state transition and on each counted pill, so a timeout fires exactly TIMEOUT*TICK_DIV cycles after the clearing event.
- Priority each cycle: emergency_stop > conveyor_fault > pill edge > timeout > other events.
- Any state except FATAL: emergency_stop high -> FATAL next cycle.
- SETTING: all outputs 0.
  - start edge with 1<=set_pills<=MAX_PILLS and 1<=set_bottles<=MAX_BOTTLES: latch targets, clear now_pills/now_bottles/err_count, go to RUNNING.
  - Out-of-range start ignored.
- RUNNING: hopper_en=1. Pill edge increments now_pills. When the increment reaches target:
  - If now_bottles+1==target_bottles: now_bottles++, go to DONE; now_pills holds the final value.
  - Else: now_bottles++, now_pills=0, go to SWITCHING.
  - HOPPER_TIMEOUT ticks without a pill: go to ERROR.
  - conveyor_fault: go to ERROR.
- SWITCHING: hopper_en=0, conveyor_run=1; pill edges ignored (not counted).
  - bottle_ready high: go to RUNNING.
  - SWITCH_TIMEOUT ticks elapsed, or conveyor_fault: go to ERROR.
- ERROR: hopper_en=0, conveyor_run=0, beep_mode=2.
  - On entry, err_count++ and the source state (RUNNING/SWITCHING) is saved.
  - If err_count reaches MAX_RETRY on entry: go straight to FATAL next cycle.
  - ack edge with conveyor_fault low: return to the saved state; counters are preserved.
  - ack while the fault is still high is ignored.
- FATAL: all enables 0, beep_mode=3. Exited only by clr_n.
- DONE: done=1, beep_mode=1 for DONE_BEEP_S ticks, then 0.
  - start edge: go to SETTING; counters hold until the next valid start.
- Counters never exceed their targets; no wrap-around is possible with legal targets.
- Simultaneous events:
  - Final pill plus emergency_stop in the same cycle: FATAL, pill not counted.
  - Pill plus hopper timeout in the same cycle: pill wins.

Test Plan:
- Reset, set_pills=3, set_bottles=2, start, 3 pills, bottle_ready, 3 pills -> state 001->010->001->011; now_bottles=2; done=1; beep_mode=1 for 2000 cycles, then 0.
- set_pills=0 or 1000, start -> state stays 000; now_pills=0.
- RUNNING, no pills for 5000 cycles -> ERROR at exactly cycle 5000, beep_mode=2; ack -> RUNNING with now_pills unchanged.
- Three successive hopper timeouts, each acked -> third ERROR entry goes to FATAL, beep_mode=3; ack ignored; clr_n low -> SETTING, all zeros.
- SWITCHING with conveyor_fault held high, ack -> stays ERROR; drop the fault, ack -> SWITCHING, conveyor_run=1.
- Emergency_stop asserted on the cycle of the final pill edge -> FATAL; now_pills not incremented; hopper_en=0 next cycle.

Source files
------------

// File: rtl/bottling_ctrl_param.sv
// Pill-bottling main controller: SETTING/RUNNING/SWITCHING/DONE/ERROR/FATAL
// sequencing with pill/bottle counters, hopper and bottle-switch timeout
// supervision, a bounded error-retry budget and beep-mode generation.
module bottling_ctrl_param #(
  parameter int PILL_W         = 10,
  parameter int BOTTLE_W       = 7,
  parameter int MAX_PILLS      = 999,
  parameter int MAX_BOTTLES    = 99,
  parameter int TICK_DIV       = 1000,
  parameter int HOPPER_TIMEOUT = 5,
  parameter int SWITCH_TIMEOUT = 3,
  parameter int MAX_RETRY      = 3,
  parameter int DONE_BEEP_S    = 2
) (
  input  logic                clk_1khz,
  input  logic                clr_n,
  input  logic                start,
  input  logic                ack,
  input  logic                emergency_stop,
  input  logic                hopper_pulse,
  input  logic                bottle_ready,
  input  logic                conveyor_fault,
  input  logic [PILL_W-1:0]   set_pills,
  input  logic [BOTTLE_W-1:0] set_bottles,
  output logic [2:0]          state,
  output logic [PILL_W-1:0]   now_pills,
  output logic [BOTTLE_W-1:0] now_bottles,
  output logic                hopper_en,
  output logic                conveyor_run,
  output logic                done,
  output logic [1:0]          beep_mode
);

  typedef enum logic [2:0] {
    S_SETTING   = 3'd0,
    S_RUNNING   = 3'd1,
    S_SWITCHING = 3'd2,
    S_DONE      = 3'd3,
    S_ERROR     = 3'd4,
    S_FATAL     = 3'd5
  } state_t;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMR_W  = 8;
  localparam int ERR_W  = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]   TICK_ONE  = TICK_W'(1);
  localparam logic [TMR_W-1:0]    TMR_MAX   = '1;
  localparam logic [TMR_W-1:0]    TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]    HOP_LAST  = TMR_W'(HOPPER_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]    SW_LAST   = TMR_W'(SWITCH_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]    BEEP_LAST = TMR_W'(DONE_BEEP_S - 1);
  localparam logic [ERR_W-1:0]    ERR_LIMIT = ERR_W'(MAX_RETRY);
  localparam logic [ERR_W-1:0]    ERR_ONE   = ERR_W'(1);
  localparam logic [PILL_W-1:0]   PILL_MAX  = PILL_W'(MAX_PILLS);
  localparam logic [PILL_W-1:0]   PILL_ONE  = PILL_W'(1);
  localparam logic [BOTTLE_W-1:0] BOT_MAX   = BOTTLE_W'(MAX_BOTTLES);
  localparam logic [BOTTLE_W-1:0] BOT_ONE   = BOTTLE_W'(1);

  state_t              state_q, state_d, src_q;
  logic                hop_s1_q, hop_s2_q, hop_prev_q;
  logic                start_prev_q, ack_prev_q;
  logic [TICK_W-1:0]   tick_cnt_q;
  logic [TMR_W-1:0]    timer_q;
  logic [ERR_W-1:0]    err_cnt_q;
  logic [PILL_W-1:0]   pills_q, tgt_pills_q;
  logic [BOTTLE_W-1:0] bottles_q, tgt_bottles_q;
  logic                hopper_en_q, conveyor_run_q, done_q;
  logic [1:0]          beep_q;

  logic pill_edge, start_edge, ack_edge, tick, set_ok;
  logic last_pill, last_bottle, tmo_hopper, tmo_switch;
  logic count_pill, err_entry, state_change;

  assign pill_edge   = hop_s2_q & ~hop_prev_q;
  assign start_edge  = start & ~start_prev_q;
  assign ack_edge    = ack & ~ack_prev_q;
  assign tick        = (tick_cnt_q == TICK_LAST);
  assign tmo_hopper  = tick && (timer_q == HOP_LAST);
  assign tmo_switch  = tick && (timer_q == SW_LAST);
  assign set_ok      = (set_pills != '0) && (set_pills <= PILL_MAX) &&
                       (set_bottles != '0) && (set_bottles <= BOT_MAX);
  assign last_pill   = ((pills_q + PILL_ONE) == tgt_pills_q);
  assign last_bottle = ((bottles_q + BOT_ONE) == tgt_bottles_q);
  assign err_entry   = (state_d == S_ERROR) && (state_q != S_ERROR);
  assign state_change = (state_d != state_q);

  // Next-state selection; emergency stop overrides everything else, including a pill
  always_comb begin
    state_d    = state_q;
    count_pill = 1'b0;
    unique case (state_q)
      S_SETTING:   if (start_edge && set_ok) state_d = S_RUNNING;
      S_RUNNING: begin
        if (conveyor_fault) begin
          state_d = S_ERROR;
        end else if (pill_edge) begin
          count_pill = 1'b1;
          if (last_pill) state_d = last_bottle ? S_DONE : S_SWITCHING;
        end else if (tmo_hopper) begin
          state_d = S_ERROR;
        end
      end
      S_SWITCHING: begin
        if (conveyor_fault || tmo_switch) state_d = S_ERROR;
        else if (bottle_ready)            state_d = S_RUNNING;
      end
      S_ERROR: begin
        if (err_cnt_q >= ERR_LIMIT)              state_d = S_FATAL;
        else if (ack_edge && !conveyor_fault)    state_d = src_q;
      end
      S_DONE:      if (start_edge) state_d = S_SETTING;
      default:     state_d = state_q;
    endcase
    if (emergency_stop && (state_q != S_FATAL)) begin
      state_d    = S_FATAL;
      count_pill = 1'b0;
    end
  end

  // State, input edge detection, timing, counters and registered outputs
  always_ff @(posedge clk_1khz or negedge clr_n) begin
    if (!clr_n) begin
      state_q        <= S_SETTING;
      src_q          <= S_SETTING;
      hop_s1_q       <= 1'b0;
      hop_s2_q       <= 1'b0;
      hop_prev_q     <= 1'b0;
      start_prev_q   <= 1'b0;
      ack_prev_q     <= 1'b0;
      tick_cnt_q     <= '0;
      timer_q        <= '0;
      err_cnt_q      <= '0;
      pills_q        <= '0;
      tgt_pills_q    <= '0;
      bottles_q      <= '0;
      tgt_bottles_q  <= '0;
      hopper_en_q    <= 1'b0;
      conveyor_run_q <= 1'b0;
      done_q         <= 1'b0;
      beep_q         <= 2'd0;
    end else begin
      hop_s1_q     <= hopper_pulse;
      hop_s2_q     <= hop_s1_q;
      hop_prev_q   <= hop_s2_q;
      start_prev_q <= start;
      ack_prev_q   <= ack;
      state_q      <= state_d;

      // Timeouts are measured from the most recent transition or counted pill
      if (state_change || count_pill) begin
        tick_cnt_q <= '0;
        timer_q    <= '0;
      end else if (tick) begin
        tick_cnt_q <= '0;
        if (timer_q != TMR_MAX) timer_q <= timer_q + TMR_ONE;
      end else begin
        tick_cnt_q <= tick_cnt_q + TICK_ONE;
      end

      if ((state_q == S_SETTING) && (state_d == S_RUNNING)) begin
        tgt_pills_q   <= set_pills;
        tgt_bottles_q <= set_bottles;
        pills_q       <= '0;
        bottles_q     <= '0;
        err_cnt_q     <= '0;
      end else if (count_pill) begin
        if (last_pill) begin
          bottles_q <= bottles_q + BOT_ONE;
          // The final bottle keeps its full pill count on display
          pills_q   <= last_bottle ? (pills_q + PILL_ONE) : '0;
        end else begin
          pills_q <= pills_q + PILL_ONE;
        end
      end

      if (err_entry) begin
        err_cnt_q <= err_cnt_q + ERR_ONE;
        src_q     <= state_q;
      end

      hopper_en_q    <= (state_d == S_RUNNING);
      conveyor_run_q <= (state_d == S_SWITCHING);
      done_q         <= (state_d == S_DONE);
      unique case (state_d)
        S_ERROR: beep_q <= 2'd2;
        S_FATAL: beep_q <= 2'd3;
        S_DONE: begin
          if (state_q != S_DONE)              beep_q <= 2'd1;
          else if (tick && timer_q == BEEP_LAST) beep_q <= 2'd0;
        end
        default: beep_q <= 2'd0;
      endcase
    end
  end

  assign state        = state_q;
  assign now_pills    = pills_q;
  assign now_bottles  = bottles_q;
  assign hopper_en    = hopper_en_q;
  assign conveyor_run = conveyor_run_q;
  assign done         = done_q;
  assign beep_mode    = beep_q;

endmodule

// File: tb/tb_bottling_ctrl_param.sv
// Scoreboard bench for bottling_ctrl_param: a cycle-level behavioural model
// pushes the expected outputs after every clock edge, a monitor pops and
// compares them against the DUT on the falling edge.
module tb_bottling_ctrl_param;

  localparam int PILL_W = 10, BOTTLE_W = 7, MAX_PILLS = 999, MAX_BOTTLES = 99;
  localparam int TICK_DIV = 1000, HOPPER_TIMEOUT = 5, SWITCH_TIMEOUT = 3;
  localparam int MAX_RETRY = 3, DONE_BEEP_S = 2;
  localparam int SET = 0, RUN = 1, SW = 2, DN = 3, ERR = 4, FAT = 5;

  logic clk = 1'b0;
  logic clr_n = 1'b0, start = 1'b0, ack = 1'b0, emergency_stop = 1'b0;
  logic hopper_pulse = 1'b0, bottle_ready = 1'b0, conveyor_fault = 1'b0;
  logic [PILL_W-1:0]   set_pills = '0;
  logic [BOTTLE_W-1:0] set_bottles = '0;
  logic [2:0]          state;
  logic [PILL_W-1:0]   now_pills;
  logic [BOTTLE_W-1:0] now_bottles;
  logic hopper_en, conveyor_run, done;
  logic [1:0] beep_mode;

  bottling_ctrl_param #(
    .PILL_W(PILL_W), .BOTTLE_W(BOTTLE_W), .MAX_PILLS(MAX_PILLS),
    .MAX_BOTTLES(MAX_BOTTLES), .TICK_DIV(TICK_DIV),
    .HOPPER_TIMEOUT(HOPPER_TIMEOUT), .SWITCH_TIMEOUT(SWITCH_TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .DONE_BEEP_S(DONE_BEEP_S)
  ) dut (
    .clk_1khz(clk), .clr_n(clr_n), .start(start), .ack(ack),
    .emergency_stop(emergency_stop), .hopper_pulse(hopper_pulse),
    .bottle_ready(bottle_ready), .conveyor_fault(conveyor_fault),
    .set_pills(set_pills), .set_bottles(set_bottles), .state(state),
    .now_pills(now_pills), .now_bottles(now_bottles), .hopper_en(hopper_en),
    .conveyor_run(conveyor_run), .done(done), .beep_mode(beep_mode)
  );

  always #5 clk = ~clk;

  typedef logic [24:0] obs_t;
  obs_t exp_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;

  // Reference model: machine state, counts, targets and "edges since the last
  // clearing event" (age) instead of a tick/seconds split.
  int ms = SET, mp = 0, mb = 0, tp = 0, tb = 0, errs = 0, saved = SET, age = 0, mbeep = 0;
  bit hs0 = 0, hs1 = 0, hs2 = 0, sprev = 0, aprev = 0;

  function automatic obs_t pack(int st, int p, int b, bit h, bit c, bit d, int bp);
    return {3'(st), 10'(p), 7'(b), h, c, d, 2'(bp)};
  endfunction

  task automatic model_step();
    int nxt;
    bit pill, sedge, aedge, clr;
    if (!clr_n) begin
      ms = SET; mp = 0; mb = 0; tp = 0; tb = 0; errs = 0; saved = SET; age = 0;
      hs0 = 0; hs1 = 0; hs2 = 0; sprev = 0; aprev = 0; mbeep = 0;
    end else begin
      // a pill is seen three edges after the raw pulse rises
      pill  = hs1 && !hs2;
      sedge = start && !sprev;
      aedge = ack && !aprev;
      hs2 = hs1; hs1 = hs0; hs0 = hopper_pulse; sprev = start; aprev = ack;
      age++;
      nxt = ms;
      clr = 0;
      if (emergency_stop && ms != FAT) nxt = FAT;
      else case (ms)
        SET: if (sedge && set_pills >= 1 && set_pills <= MAX_PILLS &&
                 set_bottles >= 1 && set_bottles <= MAX_BOTTLES) begin
               tp = set_pills; tb = set_bottles; mp = 0; mb = 0; errs = 0; nxt = RUN;
             end
        RUN: if (conveyor_fault) nxt = ERR;
             else if (pill) begin
               clr = 1;
               if (mp + 1 == tp) begin
                 mb++;
                 if (mb == tb) begin mp = tp; nxt = DN; end
                 else begin mp = 0; nxt = SW; end
               end else mp++;
             end else if (age == HOPPER_TIMEOUT * TICK_DIV) nxt = ERR;
        SW:  if (conveyor_fault || age == SWITCH_TIMEOUT * TICK_DIV) nxt = ERR;
             else if (bottle_ready) nxt = RUN;
        ERR: if (errs >= MAX_RETRY) nxt = FAT;
             else if (aedge && !conveyor_fault) nxt = saved;
        DN:  if (sedge) nxt = SET;
        default: ;
      endcase
      if (nxt == ERR && ms != ERR) begin errs++; saved = ms; end
      if (nxt != ms || clr) age = 0;
      ms = nxt;
      case (ms)
        ERR: mbeep = 2;
        FAT: mbeep = 3;
        DN:  mbeep = (age < DONE_BEEP_S * TICK_DIV) ? 1 : 0;
        default: mbeep = 0;
      endcase
    end
    exp_q.push_back(pack(ms, mp, mb, ms == RUN, ms == SW, ms == DN, mbeep));
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0; step();
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(); ack = 1'b0; step();
  endtask

  task automatic drop_pill();
    hopper_pulse = 1'b1; step(); hopper_pulse = 1'b0; step(4);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    clr_n = 1'b0;
    step(3);
    clr_n = 1'b1;
    step();
  endtask

  // Monitor: compare DUT outputs with the oldest expectation each falling edge
  initial begin
    obs_t e, g;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {state, now_pills, now_bottles, hopper_en, conveyor_run, done, beep_mode};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL outputs cycle %0d: got st=%0d p=%0d b=%0d hen=%0b crun=%0b done=%0b beep=%0d, required st=%0d p=%0d b=%0d hen=%0b crun=%0b done=%0b beep=%0d",
                   cyc, g[24:22], g[21:12], g[11:5], g[4], g[3], g[2], g[1:0],
                   e[24:22], e[21:12], e[11:5], e[4], e[3], e[2], e[1:0]);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized run
  initial begin
    step(3);
    clr_n = 1'b1;
    step(2);

    // illegal targets are ignored
    set_pills = 10'd0;    set_bottles = 7'd2; pulse_start(); step(3);
    set_pills = 10'd1000; set_bottles = 7'd2; pulse_start(); step(3);
    set_pills = 10'd3;    set_bottles = 7'd100; pulse_start(); step(3);

    // normal two-bottle run through DONE and the beep window
    set_pills = 10'd3; set_bottles = 7'd2; pulse_start(); step(2);
    repeat (3) drop_pill();
    step(20);
    bottle_ready = 1'b1; step(); bottle_ready = 1'b0; step(2);
    repeat (3) drop_pill();
    step(2100);
    pulse_start(); step(3);

    // hopper timeouts: retry budget exhausted on the third ERROR entry
    set_pills = 10'd5; set_bottles = 7'd3; pulse_start();
    repeat (2) drop_pill();
    step(5100); pulse_ack(); step(3);
    step(5100); pulse_ack(); step(3);
    step(5100); pulse_ack(); step(5);
    do_reset();

    // conveyor fault during SWITCHING, acknowledged only once cleared
    set_pills = 10'd1; set_bottles = 7'd3; pulse_start();
    drop_pill(); step(3);
    conveyor_fault = 1'b1; step(3);
    pulse_ack(); step(3);
    conveyor_fault = 1'b0; step(2);
    pulse_ack(); step(5);
    bottle_ready = 1'b1; step(); bottle_ready = 1'b0; step(3);
    do_reset();

    // emergency stop coincident with the final pill being counted
    set_pills = 10'd2; set_bottles = 7'd1; pulse_start();
    drop_pill();
    hopper_pulse = 1'b1; step(); hopper_pulse = 1'b0; step();
    emergency_stop = 1'b1; step(); emergency_stop = 1'b0; step(4);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 30000; i++) begin
      hopper_pulse   = ($urandom_range(0, 24) == 0);
      bottle_ready   = ($urandom_range(0, 39) == 0);
      ack            = ($urandom_range(0, 59) == 0);
      conveyor_fault = ($urandom_range(0, 2999) == 0);
      emergency_stop = ($urandom_range(0, 14999) == 0);
      start          = ($urandom_range(0, 149) == 0);
      if (start) begin
        if ($urandom_range(0, 9) == 0) begin
          set_pills = 10'd1000; set_bottles = 7'd100;
        end else begin
          set_pills   = PILL_W'($urandom_range(0, 6));
          set_bottles = BOTTLE_W'($urandom_range(0, 4));
        end
      end
      step();
      if (ms == FAT && $urandom_range(0, 99) == 0) begin
        hopper_pulse = 1'b0; bottle_ready = 1'b0; ack = 1'b0;
        conveyor_fault = 1'b0; emergency_stop = 1'b0; start = 1'b0;
        do_reset();
      end
    end
    hopper_pulse = 1'b0; bottle_ready = 1'b0; ack = 1'b0;
    conveyor_fault = 1'b0; emergency_stop = 1'b0; start = 1'b0;
    step(3);

    // drain the scoreboard within a bounded number of cycles
    repeat (10) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
